exe_result_commit: RTL and testbench
====================================

// Module: exe_result_commit
// PURPOSE
//  Consumer end of the execute-stage result interface. Accepts one ALU result (result, zero flag,
//  branch target) with its control bits via valid/ready, performs a data-memory load/store for
//  memory ops over a variable-latency req/ack bus, then commits: register-file write, PC redirect,
//  or bus error. Sits between the execute ALU and the register file / data memory / IFetch.
// PARAMETERS
//  DATA_W   32   width of ALU result, memory address and data
//  TIMEOUT  255  max cycles mem_req may wait for mem_ack before the op aborts (1..65535)
// PORTS
//  clock         in   1       single clock, all state changes on rising edge
//  reset_n       in   1       asynchronous reset, active-low
//  ex_valid      in   1       execute stage presents a result this cycle
//  ex_ready      out  1       block can accept; transfer when ex_valid && ex_ready
//  alu_result    in   DATA_W  ALU output; memory address for loads/stores
//  zero          in   1       ALU zero flag
//  addr_result   in   DATA_W  computed branch target
//  store_data    in   DATA_W  Read_data_2 value for stores
//  write_reg     in   5       destination register number
//  reg_write     in   1       instruction writes a register
//  mem_read      in   1       load
//  mem_write     in   1       store (mem_read && mem_write: treated as load only)
//  branch        in   1       beq-type: taken when zero==1
//  nbranch       in   1       bne-type: taken when zero==0
//  mem_req       out  1       memory request, held until mem_ack or timeout
//  mem_we        out  1       1 = store
//  mem_addr      out  DATA_W  latched alu_result
//  mem_wdata     out  DATA_W  latched store_data
//  mem_ack       in   1       memory done this cycle; mem_rdata valid for reads
//  mem_rdata     in   DATA_W  load data
//  rf_we         out  1       one-cycle register-file write strobe
//  rf_waddr      out  5       register number for rf_we
//  rf_wdata      out  DATA_W  alu_result, or load data for loads
//  pc_redirect   out  1       one-cycle strobe: taken branch
//  redirect_pc   out  DATA_W  latched addr_result
//  bus_error     out  1       one-cycle strobe: memory timeout
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 except ex_ready=1. Latches and counter cleared. Reset asserted
//   mid-op drops mem_req immediately. A late mem_ack after reset is ignored.
//  FSM: IDLE -> MEM (accept with mem_read|mem_write) | WB (accept, no memory op).
//   MEM -> WB on mem_ack. MEM -> ERR when the wait counter reaches TIMEOUT.
//   WB -> IDLE; ERR -> IDLE. Each transition takes 1 cycle.
//  ex_ready = (state==IDLE). It is combinational from state only, never from ex_valid.
//   Inputs are captured only on the accept edge.
//  MEM: mem_req=1 with mem_we/addr/wdata stable from the cycle after accept until the ack cycle.
//   A same-cycle mem_ack in the first MEM cycle is legal. rdata is captured on the ack edge.
//   The wait counter starts at 0 on entry and increments each MEM cycle without ack.
//   When count==TIMEOUT-1 with no ack, the next state is ERR.
//  WB (one cycle): rf_we = reg_write && write_reg!=0. Writes to $0 are suppressed.
//   rf_wdata = mem_read ? captured rdata : alu_result.
//   pc_redirect = (branch && zero) || (nbranch && !zero).
//  ERR (one cycle): bus_error=1. rf_we=0 and pc_redirect=0 (op aborted).
//  Latency: non-memory accept at edge N -> WB strobes visible after edge N+1.
//   Memory op: WB follows the ack edge by 1 cycle.
//  Throughput: one op per 2 cycles (non-memory), mem latency + 2 otherwise.
//  Strobes (rf_we, pc_redirect, bus_error) are registered and last exactly one cycle.
//   rf_waddr/rf_wdata/redirect_pc hold their last value otherwise.
// TESTING
//  1 ADD: alu_result=0x0000_0011, write_reg=8, reg_write=1 -> rf_we 1 cycle, waddr=8,
//    wdata=0x11, 2 cycles accept-to-accept.
//  2 Load: alu_result=0x100, mem_read=1, write_reg=9, ack after 3 cycles with rdata=0xDEADBEEF ->
//    mem_req high 3 cycles, mem_addr=0x100, mem_we=0, then rf_we with wdata=0xDEADBEEF.
//  3 Store: mem_write=1, store_data=0xA5A5_A5A5, reg_write=0, same-cycle ack -> one mem_req
//    cycle with mem_we=1, no rf_we.
//  4 Branch: branch=1/zero=1/addr_result=0x40 -> pc_redirect=1, redirect_pc=0x40.
//    nbranch=1/zero=1 -> no redirect. write_reg=0/reg_write=1 -> rf_we stays 0.
//  5 Timeout: TIMEOUT=4, load, no ack -> mem_req 4 cycles, bus_error 1 cycle, no rf_we, ex_ready
//    back to 1.
//  6 reset_n low in MEM -> mem_req=0 asynchronously. After release: ex_ready=1, a stray ack gives
//    no rf_we.

Source files
------------

// File: rtl/exe_result_commit.sv
// Execute-stage result consumer: accepts one ALU result, runs an optional data-memory
// load/store over a req/ack bus, then commits a register write, a PC redirect or a bus error.
module exe_result_commit #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero,
  input  logic [DATA_W-1:0] addr_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        write_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch,
  input  logic              nbranch,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              bus_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic [15:0]       wait_cnt;
  logic              lat_reg_write;
  logic [4:0]        lat_waddr;
  logic              lat_mem_read;
  logic              lat_taken;
  logic [DATA_W-1:0] lat_target;
  logic [DATA_W-1:0] lat_rdata;

  assign accept = ex_valid && ex_ready;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an ack in the last allowed wait cycle still wins over the timeout
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mem_read || mem_write) begin
            next_state = MEM;
          end else begin
            next_state = WB;
          end
        end else begin
          next_state = IDLE;
        end
      end
      MEM: begin
        if (mem_ack) begin
          next_state = WB;
        end else if (wait_cnt == LAST_WAIT) begin
          next_state = ERR;
        end else begin
          next_state = MEM;
        end
      end
      WB:      next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake output depends on state only
  always_comb begin
    ex_ready = (state == IDLE);
  end

  // Operand capture on accept, load data on ack, wait counter while in MEM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      lat_reg_write <= 1'b0;
      lat_waddr     <= 5'd0;
      lat_mem_read  <= 1'b0;
      lat_taken     <= 1'b0;
      lat_target    <= '0;
      lat_rdata     <= '0;
      wait_cnt      <= 16'd0;
    end else begin
      if (accept) begin
        mem_we        <= mem_write && !mem_read;
        mem_addr      <= alu_result;
        mem_wdata     <= store_data;
        lat_reg_write <= reg_write;
        lat_waddr     <= write_reg;
        lat_mem_read  <= mem_read;
        lat_taken     <= (branch && zero) || (nbranch && !zero);
        lat_target    <= addr_result;
        wait_cnt      <= 16'd0;
      end else if (state == MEM) begin
        if (mem_ack) begin
          lat_rdata <= mem_rdata;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
      end
    end
  end

  // Registered bus request and commit strobes; commit data holds until the next WB
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req     <= 1'b0;
      rf_we       <= 1'b0;
      rf_waddr    <= 5'd0;
      rf_wdata    <= '0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      bus_error   <= 1'b0;
    end else begin
      mem_req     <= (next_state == MEM);
      rf_we       <= (state == WB) && lat_reg_write && (lat_waddr != 5'd0);
      pc_redirect <= (state == WB) && lat_taken;
      bus_error   <= (state == ERR);
      if (state == WB) begin
        rf_waddr    <= lat_waddr;
        rf_wdata    <= lat_mem_read ? lat_rdata : mem_addr;
        redirect_pc <= lat_target;
      end
    end
  end

endmodule

// File: tb/tb_exe_result_commit.sv
// Randomized bench for exe_result_commit: each op's expected bus activity and commit
// outcome is derived from the op fields and the chosen ack delay.
module tb_exe_result_commit;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [DW-1:0] alu_result = '0;
  logic          zero = 1'b0;
  logic [DW-1:0] addr_result = '0;
  logic [DW-1:0] store_data = '0;
  logic [4:0]    write_reg = 5'd0;
  logic          reg_write = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic          branch = 1'b0;
  logic          nbranch = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          pc_redirect;
  logic [DW-1:0] redirect_pc;
  logic          bus_error;

  int n_checks = 0;
  int n_errors = 0;

  exe_result_commit #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .zero(zero), .addr_result(addr_result),
    .store_data(store_data), .write_reg(write_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .nbranch(nbranch),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble();
    alu_result  = $urandom;
    addr_result = $urandom;
    store_data  = $urandom;
    write_reg   = 5'($urandom);
    {zero, reg_write, mem_read, mem_write, branch, nbranch} = 6'($urandom);
  endtask

  // One full op: present, accept, serve the bus with ack after `delay` cycles (>= TO: none)
  task automatic do_op(input logic [31:0] a, input logic z, input logic [31:0] tgt,
                       input logic [31:0] sd, input logic [4:0] wr, input logic rw,
                       input logic mr, input logic mw, input logic br, input logic nb,
                       input int delay, input logic [31:0] rdata);
    bit is_mem, timed_out, taken, exp_rf;
    int reqs, waited;
    is_mem    = mr || mw;
    timed_out = is_mem && (delay >= TO);
    taken     = (br && z) || (nb && !z);
    exp_rf    = rw && (wr != 5'd0) && !timed_out;
    waited    = 0;
    while (ex_ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    check("ready_before_accept", 32'(ex_ready), 32'd1);
    alu_result = a; zero = z; addr_result = tgt; store_data = sd; write_reg = wr;
    reg_write = rw; mem_read = mr; mem_write = mw; branch = br; nbranch = nb;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    scramble();
    check("ready_after_accept", 32'(ex_ready), 32'd0);
    if (is_mem) begin
      reqs = 0;
      for (int c = 0; c < TO; c++) begin
        if (mem_req === 1'b1) reqs++;
        check("mem_we", 32'(mem_we), 32'(mw && !mr));
        check("mem_addr", mem_addr, a);
        check("mem_wdata", mem_wdata, sd);
        mem_ack   = (c == delay);
        mem_rdata = (c == delay) ? rdata : 32'($urandom);
        tick();
        mem_ack = 1'b0;
        if (c == delay) break;
      end
      check("mem_req_cycles", 32'(reqs), timed_out ? 32'(TO) : 32'(delay + 1));
      check("mem_req_drop", 32'(mem_req), 32'd0);
    end
    check("no_early_strobe", 32'({rf_we, pc_redirect, bus_error}), 32'd0);
    tick();
    check("rf_we", 32'(rf_we), 32'(exp_rf));
    check("pc_redirect", 32'(pc_redirect), 32'(taken && !timed_out));
    check("bus_error", 32'(bus_error), 32'(timed_out));
    check("ready_back", 32'(ex_ready), 32'd1);
    if (exp_rf) begin
      check("rf_waddr", 32'(rf_waddr), 32'(wr));
      check("rf_wdata", rf_wdata, mr ? rdata : a);
    end
    if (taken && !timed_out) check("redirect_pc", redirect_pc, tgt);
    tick();
    check("strobes_one_cycle", 32'({rf_we, pc_redirect, bus_error}), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_ready", 32'(ex_ready), 32'd1);
    check("rst_outputs", 32'({mem_req, mem_we, rf_we, pc_redirect, bus_error}), 32'd0);
    check("rst_data", mem_addr | rf_wdata | redirect_pc, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    do_op(32'h11, 1'b0, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    do_op(32'h100, 1'b0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32'hDEADBEEF);
    do_op(32'h200, 1'b0, 32'h0, 32'hA5A5A5A5, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    do_op(32'h0, 1'b1, 32'h40, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0);
    do_op(32'h0, 1'b1, 32'h80, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    do_op(32'h300, 1'b0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, TO, 32'h0);
    do_op(32'h400, 1'b0, 32'h0, 32'h1234, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'hCAFEF00D);

    for (int i = 0; i < 60; i++) begin
      do_op($urandom, 1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, TO)), $urandom);
    end

    // Reset in the middle of a load, then a stray ack
    alu_result = 32'h500; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
    write_reg = 5'd7; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    check("pre_reset_req", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_req_drop", 32'(mem_req), 32'd0);
    check("reset_ready", 32'(ex_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h55AA55AA;
    tick();
    mem_ack = 1'b0;
    tick();
    check("stray_ack_rf", 32'({rf_we, mem_req, bus_error}), 32'd0);
    tick();
    check("stray_ack_rf2", 32'({rf_we, pc_redirect, bus_error}), 32'd0);
    check("post_reset_ready", 32'(ex_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
